// File: rtl/d_rca_pkg.sv
// Shared configuration helpers for the pipelined ripple-carry adder/subtractor.
package d_rca_pkg;

    function automatic int nstage(input int width, input int seg);
        return width / seg;
    endfunction

    function automatic bit cfg_ok(input int width, input int seg);
        return (seg > 0) && (width >= seg) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/d_rca_seg.sv
// Combinational SEG-bit ripple slice: sum and carry-out of every bit position.
module d_rca_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] i_a,
    input  logic [SEG-1:0] i_b,
    input  logic           i_cin,
    output logic [SEG-1:0] o_sum,
    output logic [SEG-1:0] o_carry
);

    always_comb begin
        logic c;
        o_sum   = '0;
        o_carry = '0;
        c       = i_cin;
        // NOTE: blocking assignments here are deliberate; c must ripple through
        // the loop within one evaluation, which non-blocking would not do.
        for (int i = 0; i < SEG; i++) begin
            o_sum[i]   = i_a[i] ^ i_b[i] ^ c;
            o_carry[i] = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
            c          = o_carry[i];
        end
    end

endmodule

// File: rtl/d_rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage,
// valid/ready on both sides, stalls collapse bubbles.
module d_rca_pipe
    import d_rca_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic [WIDTH-1:0] out_carry,
    output logic             out_ovf
);

    localparam int NSTAGE = nstage(WIDTH, SEG);

    if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_err
        $error("d_rca_pipe: WIDTH must be a non-zero multiple of SEG");
    end

    // Operands travel with the partial result; c is the carry handed to the next segment.
    typedef struct packed {
        logic             vld;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] carry;
        logic             c;
        logic             ovf;
    } stage_t;

    stage_t              r_stg [NSTAGE];
    logic [NSTAGE-1:0]   w_load;

    // A stage loads when empty or when the stage after it is loading.
    always_comb begin
        logic ld;
        w_load = '0;
        ld     = out_ready;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            ld        = !r_stg[k].vld | ld;
            w_load[k] = ld;
        end
    end

    assign in_ready = rst_n & w_load[0];

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        stage_t         w_src;
        stage_t         w_nxt;
        logic [SEG-1:0] w_seg_sum;
        logic [SEG-1:0] w_seg_carry;
        logic           w_cin_msb;

        if (k == 0) begin : g_src_in
            always_comb begin
                w_src     = '0;
                w_src.vld = in_valid;
                w_src.a   = in_a;
                w_src.b   = in_sub ? ~in_b : in_b;
                w_src.c   = in_sub | in_cin;
            end
        end else begin : g_src_stage
            assign w_src = r_stg[k-1];
        end

        d_rca_seg #(.SEG(SEG)) u_seg (
            .i_a     (w_src.a[k*SEG +: SEG]),
            .i_b     (w_src.b[k*SEG +: SEG]),
            .i_cin   (w_src.c),
            .o_sum   (w_seg_sum),
            .o_carry (w_seg_carry)
        );

        if (SEG > 1) begin : g_cmsb_seg
            assign w_cin_msb = w_seg_carry[SEG-2];
        end else begin : g_cmsb_in
            assign w_cin_msb = w_src.c;
        end

        // ovf is only meaningful once the top segment has been resolved.
        always_comb begin
            w_nxt                       = w_src;
            w_nxt.sum[k*SEG +: SEG]     = w_seg_sum;
            w_nxt.carry[k*SEG +: SEG]   = w_seg_carry;
            w_nxt.c                     = w_seg_carry[SEG-1];
            w_nxt.ovf                   = w_cin_msb ^ w_seg_carry[SEG-1];
        end

        // NOTE: the data fields are reset as well as the valid flag, because the
        // result outputs are driven straight from the last stage and must read 0.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stg[k] <= '0;
            end else if (w_load[k]) begin
                if (w_src.vld) begin
                    r_stg[k] <= w_nxt;
                end else begin
                    r_stg[k].vld <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_stg[NSTAGE-1].vld;
    assign out_sum   = r_stg[NSTAGE-1].sum;
    assign out_cout  = r_stg[NSTAGE-1].c;
    assign out_carry = r_stg[NSTAGE-1].carry;
    assign out_ovf   = r_stg[NSTAGE-1].ovf;

endmodule

// File: tb/tb_d_rca_pipe.sv
// Randomised self-checking bench for d_rca_pipe against an arithmetic FIFO model.
module tb_d_rca_pipe;

    localparam int W = 16;
    localparam int S = 4;
    localparam int N = W / S;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_cin = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic [W-1:0] out_carry;
    logic         out_ovf;

    d_rca_pipe #(.WIDTH(W), .SEG(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_carry (out_carry),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] sum;
        logic [W-1:0] carry;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t         q[$];
    int           last_ret = 0;
    int           n_checks = 0;
    int           n_fail = 0;
    logic         stalled_prev = 1'b0;
    logic [W-1:0] prev_sum = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result computed as plain integer arithmetic on the effective operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        exp_t       e;
        logic [W-1:0] be;
        logic [W-1:0] m;
        logic [W:0]   mw;
        logic [W:0]   full;
        logic [W:0]   part;
        logic         c0;
        be     = sub ? ~b : b;
        c0     = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, c0};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.carry = '0;
        for (int i = 0; i < W; i++) begin
            mw   = ({{W{1'b0}}, 1'b1} << (i + 1)) - 1'b1;
            m    = mw[W-1:0];
            part = {1'b0, a & m} + {1'b0, be & m} + {{W{1'b0}}, c0};
            e.carry[i] = part[i+1];
        end
        e.ovf = (a[W-1] == be[W-1]) && (e.sum[W-1] != a[W-1]);
        e.acc = 0;
        return e;
    endfunction

    // Per-cycle comparison; called after inputs settle, ahead of the next rising edge.
    task automatic compare();
        logic exp_ir;
        logic exp_ov;
        int   avail;
        exp_t e;
        exp_ir = (q.size() < N) || out_ready;
        avail  = 0;
        if (q.size() > 0) begin
            avail = q[0].acc + N - 1;
            if (last_ret > avail) avail = last_ret;
        end
        exp_ov = (q.size() > 0) && (avail <= cyc);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            check("out_sum", {16'd0, out_sum}, {16'd0, q[0].sum});
            check("out_cout", {31'd0, out_cout}, {31'd0, q[0].cout});
            check("out_carry", {16'd0, out_carry}, {16'd0, q[0].carry});
            check("out_ovf", {31'd0, out_ovf}, {31'd0, q[0].ovf});
            if (stalled_prev) check("stall_stable", {16'd0, out_sum}, {16'd0, prev_sum});
        end
        stalled_prev = exp_ov && !out_ready;
        prev_sum     = out_sum;
        if (exp_ov && out_ready) begin
            void'(q.pop_front());
            last_ret = cyc + 1;
        end
        if (in_valid && exp_ir) begin
            e     = model(in_a, in_b, in_cin, in_sub);
            e.acc = cyc + 1;
            q.push_back(e);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input logic sub, input logic ordy);
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        out_ready = ordy;
        #1;
        compare();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    logic [W-1:0] ra, rb;
    exp_t         pin;

    initial begin
        // Model pins against hand-computed values.
        pin = model(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        check("pin_wrap_sum", {16'd0, pin.sum}, 32'h0000);
        check("pin_wrap_carry", {16'd0, pin.carry}, 32'hFFFF);
        check("pin_wrap_cout", {31'd0, pin.cout}, 32'd1);
        pin = model(16'h0005, 16'h0007, 1'b0, 1'b1);
        check("pin_sub_neg_sum", {16'd0, pin.sum}, 32'hFFFE);
        check("pin_sub_neg_cout", {31'd0, pin.cout}, 32'd0);
        pin = model(16'h0007, 16'h0005, 1'b1, 1'b1);
        check("pin_sub_pos_sum", {16'd0, pin.sum}, 32'h0002);
        pin = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        check("pin_ovf_sum", {16'd0, pin.sum}, 32'h8000);
        check("pin_ovf_carry", {16'd0, pin.carry}, 32'h7FFF);
        check("pin_ovf_flag", {31'd0, pin.ovf}, 32'd1);
        pin = model(16'h1234, 16'h0FF0, 1'b1, 1'b0);
        check("pin_cin_sum", {16'd0, pin.sum}, 32'h2225);

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {16'd0, out_sum}, 32'd0);
        check("rst_out_carry", {16'd0, out_carry}, 32'd0);
        check("rst_out_flags", {30'd0, out_cout, out_ovf}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        last_ret = cyc;

        // Directed corner operations.
        drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        idle(6);

        // Eight back-to-back random operations.
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            drive(1'b1, ra, rb, 1'($urandom), 1'($urandom), 1'b1);
        end
        idle(6);

        // Full stall: four fill the pipe, the fifth waits for out_ready.
        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            drive(1'b1, ra, rb, 1'($urandom), 1'b0, 1'b0);
        end
        ra = W'($urandom);
        rb = W'($urandom);
        repeat (3) drive(1'b1, ra, rb, 1'b1, 1'b1, 1'b0);
        drive(1'b1, ra, rb, 1'b1, 1'b1, 1'b1);
        idle(8);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            drive($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3) != 0);
        end
        idle(8);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            drive(1'b1, ra, rb, 1'b0, 1'b0, 1'b1);
        end
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_out_sum", {16'd0, out_sum}, 32'd0);
        q.delete();
        stalled_prev = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        last_ret = cyc;
        drive(1'b1, 16'h1234, 16'h0FF0, 1'b1, 1'b0, 1'b1);
        idle(6);

        check("drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/d_rca_pipe.md
Name: d_rca_pipe

Overview:
Parametrised, pipelined ripple-carry adder/subtractor; next generation of the team's 4-bit ripple-carry adder. Operands split into SEG-bit segments, one segment resolved per pipeline stage, with a valid/ready handshake on both sides and bubble-collapsing stalls. Exports sum, carry-out, per-bit carry vector and signed overflow. Used as the datapath arithmetic core wherever WIDTH exceeds single-cycle ripple timing.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of SEG
SEG, 4, bits resolved per stage; NSTAGE = WIDTH/SEG, NSTAGE >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_cin  input  1  carry-in; ignored when in_sub=1
in_sub  input  1  0: A+B+cin; 1: A+~B+1 (A-B)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_sum  output  WIDTH  result
out_cout  output  1  carry out of MSB (sub: 1 = no borrow)
out_carry  output  WIDTH  carry out of every bit position, bit i = carry from bit i
out_ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, async): all stage valid flags, data, carry registers and outputs clear to 0 immediately; in_ready forced 0 while rst_n low. In-flight operations are discarded, never emitted.
- Transfer on input when in_valid & in_ready; on output when out_valid & out_ready.
- Effective B = in_sub ? ~in_b : in_b; effective cin = in_sub ? 1 : in_cin; fixed at acceptance.
- Stage k (0..NSTAGE-1) computes bits [k*SEG +: SEG] by ripple from the carry handed forward by stage k-1 (stage 0 uses effective cin); registers those sum/carry bits plus remaining unprocessed operand bits.
- Latency: NSTAGE cycles from accepting edge to out_valid (last stage is the output register). Throughput one result per cycle when out_ready=1.
- Bubble collapse: stage k loads when it is empty or stage k+1 loads (last stage: when empty or out_ready). in_ready = stage 0 empty or stage 0 advancing; combinational from out_ready permitted.
- Capacity: NSTAGE results held while out_ready=0; in_ready deasserts only when every stage is full.
- Outputs stable while out_valid & !out_ready. Order strictly FIFO; no reordering or drops.
- out_ovf/out_cout/out_carry always refer to the same operation as out_sum.
- NSTAGE=1: single registered stage, latency 1, same handshake rules.
- Simultaneous input accept and output retire with all stages full: allowed, occupancy unchanged.

Decomposition:
- Package d_rca_pkg: helper function for NSTAGE, elaboration-time check WIDTH % SEG == 0.
- Sub-module d_rca_seg: combinational SEG-bit ripple slice (a, b, cin -> sum, per-bit carry), instantiated once per stage.

Test Plan:
- WIDTH=16/SEG=4: a=0xFFFF,b=0x0001,cin=0,sub=0 -> 4 cycles later sum=0x0000, cout=1, carry=0xFFFF, ovf=0.
- a=0x0005,b=0x0007,sub=1 -> sum=0xFFFE, cout=0, ovf=0; a=0x0007,b=0x0005,sub=1 -> sum=0x0002, cout=1.
- a=0x7FFF,b=0x0001,cin=0 -> sum=0x8000, cout=0, carry=0x7FFF, ovf=1.
- 8 back-to-back random ops, out_ready=1 -> in_ready held 1, 8 results on consecutive cycles in order, match model.
- out_ready=0: exactly 4 accepted then in_ready=0, 5th held; out_ready=1 -> results 1-5 in order, out_sum stable while stalled.
- 3 ops in flight, pulse rst_n low mid-cycle -> out_valid=0 asynchronously, after release no stale results, next op correct at latency 4.
